program_loader: RTL and testbench

//  Upstream boot stage for the single-cycle CPU. Accepts a program image as a ready/valid

---
 rtl/program_loader_pkg.sv | 14 +
 rtl/program_loader_if.sv | 24 ++
 rtl/program_loader_sum_acc.sv | 34 +++
 rtl/program_loader.sv | 130 +++++++++++++
 tb/tb_program_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader: loader FSM states and word size.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN,
    ERR
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/program_loader_if.sv
// Image stream (ready/valid) and instruction-memory write port of the program loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              s_valid_i;
  logic              s_ready_o;
  logic [31:0]       s_data_i;
  logic              s_last_i;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;

  modport slave (
    input  s_valid_i, s_data_i, s_last_i,
    output s_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
  );

  modport master (
    output s_valid_i, s_data_i, s_last_i,
    input  s_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
  );

endinterface

// File: rtl/program_loader_sum_acc.sv
// Clear/accumulate 32-bit adder for the image checksum; only built when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
module loader_sum_acc (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] sum_o
);

  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/program_loader.sv
// Boot loader: streams a program image into imem, holds the CPU in reset until the load completes.
// Optional LOADER_CHECKSUM_EN: the s_last_i word is a checksum of the image instead of data.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    start_i,
  program_loader_if.slave         bus,
  output logic                    cpu_rst_n_o,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [$clog2(DEPTH):0]  word_cnt_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cpu_q, cpu_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              beat;
  logic              write_last;
  logic              sum_ok;

  assign beat = bus.s_valid_i && (state_q == LOAD);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        sum_clr;
  logic        sum_en;

  assign sum_clr    = start_i && (state_q inside {IDLE, RUN, ERR});
  assign sum_en     = beat && !bus.s_last_i;
  assign write_last = 1'b0;
  assign sum_ok     = (sum == bus.s_data_i);

  loader_sum_acc u_sum_acc (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .clr_i  (sum_clr),
    .en_i   (sum_en),
    .data_i (bus.s_data_i),
    .sum_o  (sum)
  );
`else
  assign write_last = 1'b1;
  assign sum_ok     = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RUN, ERR: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (beat) begin
          if (bus.s_last_i && !write_last) begin
            // Checksum word is only compared, never written or counted.
            state_d = sum_ok ? FLUSH : ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + ADDR_W'(WORD_BYTES) * ADDR_W'(cnt_q);
            wdata_d = bus.s_data_i;
            cnt_d   = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
            if (bus.s_last_i) begin
              state_d = FLUSH;
            end else if (cnt_q == CW'(DEPTH - 1)) begin
              state_d = ERR;
            end
          end
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = IDLE;
    endcase
    // Status flags follow the state being entered so they change on the same edge.
    cpu_d  = (state_d == RUN);
    busy_d = (state_d == LOAD) || (state_d == FLUSH);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      cnt_q   <= '0;
      cpu_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      cpu_q   <= cpu_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_ready_o    = (state_q == LOAD);
  assign bus.imem_we_o    = we_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_wdata_o = wdata_q;
  assign cpu_rst_n_o      = cpu_q;
  assign busy_o           = busy_q;
  assign err_o            = err_q;
  assign word_cnt_o       = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed boot scenarios plus randomized loads
// checked every cycle against a transaction-level model of the loader.
module tb_program_loader;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE   = 32'h0;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk_i   = 1'b0;
  logic          rst_n   = 1'b1;
  logic          start_i = 1'b0;
  logic          cpu_rst_n_o;
  logic          busy_o;
  logic          err_o;
  logic [CW-1:0] word_cnt_o;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  check_en = 1'b0;

  logic [31:0] dut_mem [logic [31:0]];

  always #5 clk_i = ~clk_i;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .bus         (bus),
    .cpu_rst_n_o (cpu_rst_n_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .word_cnt_o  (word_cnt_o)
  );

  // Transaction-level model: which phase of a boot we are in, plus the expected write.
  bit          m_loading, m_flushing, m_running, m_err, m_we;
  int          m_cnt;
  logic [31:0] m_sum, m_addr, m_wdata;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_flushing = 0; m_running = 0; m_err = 0; m_we = 0;
      m_cnt = 0; m_sum = 0; m_addr = BASE; m_wdata = 0;
    end else begin
      m_we = 0;
      if (m_loading) begin
        if (bus.s_valid_i) begin
          if (bus.s_last_i && CS) begin
            m_loading = 0;
            if (bus.s_data_i == m_sum) m_flushing = 1;
            else m_err = 1;
          end else begin
            m_we    = 1;
            m_addr  = BASE + 32'(4 * m_cnt);
            m_wdata = bus.s_data_i;
            m_sum   = m_sum + bus.s_data_i;
            m_cnt   = m_cnt + 1;
            if (bus.s_last_i) begin
              m_loading = 0; m_flushing = 1;
            end else if (m_cnt == DEPTH) begin
              m_loading = 0; m_err = 1;
            end
          end
        end
      end else if (m_flushing) begin
        m_flushing = 0; m_running = 1;
      end else if (start_i) begin
        m_loading = 1; m_running = 0; m_err = 0; m_cnt = 0; m_sum = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  // Every cycle, away from the rising edge, the DUT must match the model.
  always @(negedge clk_i) begin
    if (check_en) begin
      checkOutput("s_ready", 32'(bus.s_ready_o), 32'(m_loading));
      checkOutput("imem_we", 32'(bus.imem_we_o), 32'(m_we));
      if (m_we) begin
        checkOutput("imem_addr", bus.imem_addr_o, m_addr);
        checkOutput("imem_wdata", bus.imem_wdata_o, m_wdata);
      end
      checkOutput("cpu_rst_n", 32'(cpu_rst_n_o), 32'(m_running));
      checkOutput("busy", 32'(busy_o), 32'(m_loading | m_flushing));
      checkOutput("err", 32'(err_o), 32'(m_err));
      checkOutput("word_cnt", 32'(word_cnt_o), 32'(m_cnt));
    end
    if (bus.imem_we_o === 1'b1) dut_mem[bus.imem_addr_o] = bus.imem_wdata_o;
  end

  task automatic applyStimulus(input bit start, input bit valid, input logic [31:0] data, input bit last);
    @(negedge clk_i);
    start_i        = start;
    bus.s_valid_i  = valid;
    bus.s_data_i   = data;
    bus.s_last_i   = last;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, $urandom, 0);
  endtask

  function automatic logic [31:0] memAt(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [31:0] w [3];
    logic [31:0] sum;
    int          len;
    w[0] = 32'h2008_0005; w[1] = 32'h2009_0003; w[2] = 32'h0109_5020;
    bus.s_valid_i = 0; bus.s_data_i = 0; bus.s_last_i = 0;

    #1 rst_n = 0;
    check_en = 1;
    repeat (2) @(negedge clk_i);
    checkOutput("rst cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
    checkOutput("rst s_ready", 32'(bus.s_ready_o), 32'd0);
    checkOutput("rst imem_we", 32'(bus.imem_we_o), 32'd0);
    checkOutput("rst imem_addr", bus.imem_addr_o, BASE);
    checkOutput("rst imem_wdata", bus.imem_wdata_o, 32'd0);
    checkOutput("rst busy", 32'(busy_o), 32'd0);
    checkOutput("rst word_cnt", 32'(word_cnt_o), 32'd0);
    #2 rst_n = 1;
    idle(3);
    checkOutput("idle cpu held", 32'(cpu_rst_n_o), 32'd0);

    // Example three-word image, back to back.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, w[i], (i == 2) && !CS);
    if (CS) applyStimulus(0, 1, 32'h411A_5028, 1);
    idle(3);
    checkOutput("ex cpu_rst_n", 32'(cpu_rst_n_o), 32'd1);
    checkOutput("ex word_cnt", 32'(word_cnt_o), 32'd3);
    checkOutput("ex mem0", memAt(32'h0), w[0]);
    checkOutput("ex mem4", memAt(32'h4), w[1]);
    checkOutput("ex mem8", memAt(32'h8), w[2]);

    // Same image with gaps, reloaded from RUN.
    dut_mem.delete();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, $urandom, 0);
      applyStimulus(0, 1, w[i], (i == 2) && !CS);
    end
    if (CS) begin
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 32'h411A_5028, 1);
    end
    idle(3);
    checkOutput("gap cpu_rst_n", 32'(cpu_rst_n_o), 32'd1);
    checkOutput("gap mem8", memAt(32'h8), w[2]);

    // Overflow: five words, no last.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h1000 + 32'(i), 0);
    idle(2);
    checkOutput("ovf err", 32'(err_o), 32'd1);
    checkOutput("ovf cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
    checkOutput("ovf word_cnt", 32'(word_cnt_o), 32'd4);
    checkOutput("ovf memC", memAt(32'hC), 32'h1003);
    applyStimulus(1, 0, 0, 0);
    idle(1);
    checkOutput("ovf restart err", 32'(err_o), 32'd0);
    checkOutput("ovf restart busy", 32'(busy_o), 32'd1);
    applyStimulus(0, 1, 32'h0, 1);
    idle(3);
    checkOutput("single cpu_rst_n", 32'(cpu_rst_n_o), 32'd1);
    checkOutput("single word_cnt", 32'(word_cnt_o), CS ? 32'd0 : 32'd1);

    // Words 1, 2, then 3 as last; then 4 as last.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0); applyStimulus(0, 1, 2, 0); applyStimulus(0, 1, 3, 1);
    idle(3);
    checkOutput("sum3 cpu_rst_n", 32'(cpu_rst_n_o), 32'd1);
    checkOutput("sum3 word_cnt", 32'(word_cnt_o), CS ? 32'd2 : 32'd3);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0); applyStimulus(0, 1, 2, 0); applyStimulus(0, 1, 4, 1);
    idle(3);
    checkOutput("sum4 err", 32'(err_o), CS ? 32'd1 : 32'd0);
    checkOutput("sum4 cpu_rst_n", 32'(cpu_rst_n_o), CS ? 32'd0 : 32'd1);

    // Reload from RUN drops CPU reset on the same edge.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    idle(3);
    applyStimulus(1, 0, 0, 0);
    idle(1);
    checkOutput("reload cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
    checkOutput("reload busy", 32'(busy_o), 32'd1);

    // Abort mid-load with reset; earlier writes stay.
    applyStimulus(0, 1, 32'hAAAA_0001, 0);
    applyStimulus(0, 1, 32'hAAAA_0002, 0);
    idle(1);
    @(negedge clk_i);
    #2 rst_n = 0;
    #1;
    checkOutput("abort busy", 32'(busy_o), 32'd0);
    checkOutput("abort word_cnt", 32'(word_cnt_o), 32'd0);
    checkOutput("abort mem0", memAt(32'h0), 32'hAAAA_0001);
    checkOutput("abort mem4", memAt(32'h4), 32'hAAAA_0002);
    @(negedge clk_i);
    #2 rst_n = 1;
    idle(2);

    // Randomized loads, including stray starts, stray valids and overflows.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1, 1'($urandom), $urandom, 1'($urandom));
      len = $urandom_range(1, 6);
      sum = 0;
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 2) == 0) applyStimulus(1'($urandom), 0, $urandom, 1'($urandom));
        if (i == len - 1 && len <= DEPTH + 1) begin
          if (CS && $urandom_range(0, 1) == 1) applyStimulus(1'($urandom), 1, sum, 1);
          else applyStimulus(1'($urandom), 1, $urandom, 1);
        end else begin
          applyStimulus(1'($urandom), 1, 32'($urandom_range(0, 15)), 0);
          sum = sum + bus.s_data_i;
        end
      end
      for (int k = 0; k < 3; k++) applyStimulus(0, 1'($urandom), $urandom, 1'($urandom));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
